// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock and squash control for a 5-stage core.
// Detects load-use and jump-register hazards, and counts stall and flush cycles.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_use_rt,
    input  logic             ID_Jump,
    input  logic             ID_JumpReg,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_wr,
    input  logic             EX_BranchTaken,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_wr,
    input  logic             cnt_clear,
    output logic             PC_hold,
    output logic             IF_ID_hold,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic rs_ex;
    logic rt_ex;
    logic rs_mem;
    logic lu;
    logic jl;
    logic ja;
    logic jm;

    // register 0 never carries a dependency
    assign rs_ex  = (ID_rs != 5'd0) && (EX_wr == ID_rs);
    assign rt_ex  = (ID_rt != 5'd0) && (EX_wr == ID_rt);
    assign rs_mem = (ID_rs != 5'd0) && (MEM_wr == ID_rs);

    assign lu = EX_MemRead && (rs_ex || (ID_use_rt && rt_ex));
    assign jl = ID_JumpReg && EX_MemRead && rs_ex;
    assign ja = ID_JumpReg && EX_RegWrite && !EX_MemRead && rs_ex;
    assign jm = ID_JumpReg && MEM_MemRead && rs_mem;

    // state is reported as RUN while reset is held, even before the edge
    assign hz_state = (state == HOLD) && !reset;

    // control decode: branch squash beats stalls, stalls beat jump flush
    always_comb begin
        PC_hold     = 1'b0;
        IF_ID_hold  = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_stall = 1'b0;
        ID_EX_flush = 1'b0;
        state_nxt   = RUN;
        if (!reset) begin
            if (EX_BranchTaken) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (state == HOLD) begin
                PC_hold     = 1'b1;
                IF_ID_hold  = 1'b1;
                ID_EX_stall = 1'b1;
            end else if (jl) begin
                PC_hold     = 1'b1;
                IF_ID_hold  = 1'b1;
                ID_EX_stall = 1'b1;
                state_nxt   = HOLD;
            end else if (lu || ja || jm) begin
                PC_hold     = 1'b1;
                IF_ID_hold  = 1'b1;
                ID_EX_stall = 1'b1;
            end else if (ID_Jump) begin
                IF_ID_flush = 1'b1;
            end
        end
    end

    // FSM state register; HOLD always lasts exactly one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // saturating performance counters; clear beats increment
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ID_EX_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((IF_ID_flush || ID_EX_flush) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Runs with CNT_W=4 so counter saturation is reachable quickly.
module tb_hazard_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   ID_rs;
    logic [4:0]   ID_rt;
    logic         ID_use_rt;
    logic         ID_Jump;
    logic         ID_JumpReg;
    logic         EX_MemRead;
    logic         EX_RegWrite;
    logic [4:0]   EX_wr;
    logic         EX_BranchTaken;
    logic         MEM_MemRead;
    logic [4:0]   MEM_wr;
    logic         cnt_clear;
    logic         PC_hold;
    logic         IF_ID_hold;
    logic         IF_ID_flush;
    logic         ID_EX_stall;
    logic         ID_EX_flush;
    logic         hz_state;
    logic [W-1:0] stall_cnt;
    logic [W-1:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    // {PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_stall, ID_EX_flush}
    logic [4:0] ctl;
    assign ctl = {PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_stall, ID_EX_flush};

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11010;
    localparam logic [4:0] C_FLUSH = 5'b00101;
    localparam logic [4:0] C_JUMP  = 5'b00100;

    hazard_ctrl #(.CNT_W(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_use_rt      (ID_use_rt),
        .ID_Jump        (ID_Jump),
        .ID_JumpReg     (ID_JumpReg),
        .EX_MemRead     (EX_MemRead),
        .EX_RegWrite    (EX_RegWrite),
        .EX_wr          (EX_wr),
        .EX_BranchTaken (EX_BranchTaken),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_wr         (MEM_wr),
        .cnt_clear      (cnt_clear),
        .PC_hold        (PC_hold),
        .IF_ID_hold     (IF_ID_hold),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_stall    (ID_EX_stall),
        .ID_EX_flush    (ID_EX_flush),
        .hz_state       (hz_state),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_rs = 0; ID_rt = 0; ID_use_rt = 0; ID_Jump = 0; ID_JumpReg = 0;
        EX_MemRead = 0; EX_RegWrite = 0; EX_wr = 0; EX_BranchTaken = 0;
        MEM_MemRead = 0; MEM_wr = 0; cnt_clear = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        EX_MemRead = 1; EX_wr = 8; ID_rs = 8; EX_BranchTaken = 1; ID_Jump = 1;
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_NONE);
        end
        checks++;
        if (hz_state !== 1'b0) begin
            errors++; $display("FAIL reset_state: got %b expected 0", hz_state);
        end
        cyc(); cyc();
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        reset = 0; idle();
        cyc();
    endtask

    task automatic test_load_use();
        EX_MemRead = 1; EX_wr = 8; ID_rs = 8;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL lu_ctl: got %b expected %b", ctl, C_STALL);
        end
        cyc(); idle(); #1;
        checks++;
        if (hz_state !== 1'b0 || ctl !== C_NONE) begin
            errors++;
            $display("FAIL lu_after: got st=%b ctl=%b expected st=0 ctl=%b", hz_state, ctl, C_NONE);
        end
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_jr_after_load();
        ID_JumpReg = 1; ID_Jump = 1; ID_rs = 31; EX_MemRead = 1; EX_wr = 31;
        #1;
        checks++;
        if (ctl !== C_STALL || hz_state !== 1'b0) begin
            errors++; $display("FAIL jl_c1: got ctl=%b st=%b expected %b st=0", ctl, hz_state, C_STALL);
        end
        cyc();
        EX_MemRead = 0; EX_wr = 0; #1;
        checks++;
        if (ctl !== C_STALL || hz_state !== 1'b1) begin
            errors++; $display("FAIL jl_c2: got ctl=%b st=%b expected %b st=1", ctl, hz_state, C_STALL);
        end
        cyc();
        checks++;
        if (ctl !== C_JUMP || hz_state !== 1'b0) begin
            errors++; $display("FAIL jl_c3: got ctl=%b st=%b expected %b st=0", ctl, hz_state, C_JUMP);
        end
        cyc(); idle();
        checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
            errors++;
            $display("FAIL jl_cnt: got %0d/%0d expected 3/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_branch();
        EX_MemRead = 1; EX_wr = 8; ID_rs = 8; EX_BranchTaken = 1;
        #1;
        checks++;
        if (ctl !== C_FLUSH) begin
            errors++; $display("FAIL br_run_ctl: got %b expected %b", ctl, C_FLUSH);
        end
        cyc();
        checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd2 || hz_state !== 1'b0) begin
            errors++;
            $display("FAIL br_run_cnt: got %0d/%0d st=%b expected 3/2 st=0",
                     stall_cnt, flush_cnt, hz_state);
        end
        EX_BranchTaken = 0; ID_JumpReg = 1; ID_Jump = 1;
        cyc();
        checks++;
        if (hz_state !== 1'b1) begin
            errors++; $display("FAIL br_enter_hold: got %b expected 1", hz_state);
        end
        EX_BranchTaken = 1; #1;
        checks++;
        if (ctl !== C_FLUSH) begin
            errors++; $display("FAIL br_hold_ctl: got %b expected %b", ctl, C_FLUSH);
        end
        cyc(); idle(); #1;
        checks++;
        if (hz_state !== 1'b0 || stall_cnt !== 4'd4 || flush_cnt !== 4'd3) begin
            errors++;
            $display("FAIL br_hold_exit: got st=%b %0d/%0d expected st=0 4/3",
                     hz_state, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_terms();
        EX_MemRead = 1; EX_wr = 0; ID_rs = 0; ID_rt = 0; ID_use_rt = 1;
        ID_JumpReg = 1; EX_RegWrite = 1; MEM_MemRead = 1; MEM_wr = 0;
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL reg0: got %b expected %b", ctl, C_NONE);
        end
        idle(); EX_MemRead = 1; EX_wr = 9; ID_rt = 9; ID_use_rt = 1; ID_rs = 3; #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL lu_rt: got %b expected %b", ctl, C_STALL);
        end
        ID_use_rt = 0; #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL lu_rt_unused: got %b expected %b", ctl, C_NONE);
        end
        idle(); ID_JumpReg = 1; ID_Jump = 1; EX_RegWrite = 1; EX_wr = 5; ID_rs = 5; #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL ja: got %b expected %b", ctl, C_STALL);
        end
        cyc();
        checks++;
        if (hz_state !== 1'b0) begin
            errors++; $display("FAIL ja_state: got %b expected 0", hz_state);
        end
        idle(); ID_JumpReg = 1; ID_Jump = 1; MEM_MemRead = 1; MEM_wr = 7; ID_rs = 7; #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL jm: got %b expected %b", ctl, C_STALL);
        end
        MEM_wr = 6; #1;
        checks++;
        if (ctl !== C_JUMP) begin
            errors++; $display("FAIL jump_only: got %b expected %b", ctl, C_JUMP);
        end
        idle(); cyc();
    endtask

    task automatic test_counters();
        cnt_clear = 1; cyc(); cnt_clear = 0;
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++; $display("FAIL clr: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        EX_MemRead = 1; EX_wr = 8; ID_rs = 8;
        for (int i = 0; i < 20; i++) cyc();
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL stall_sat: got %0d expected 15", stall_cnt);
        end
        cnt_clear = 1; cyc(); cnt_clear = 0;
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++; $display("FAIL clr_win: got %0d expected 0", stall_cnt);
        end
        idle(); EX_BranchTaken = 1; cyc();
        checks++;
        if (flush_cnt !== 4'd1) begin
            errors++; $display("FAIL flush_once: got %0d expected 1", flush_cnt);
        end
        idle(); ID_Jump = 1;
        for (int i = 0; i < 20; i++) cyc();
        checks++;
        if (flush_cnt !== 4'd15) begin
            errors++; $display("FAIL flush_sat: got %0d expected 15", flush_cnt);
        end
        idle(); cyc();
    endtask

    task automatic test_reset_hold();
        ID_JumpReg = 1; ID_Jump = 1; ID_rs = 31; EX_MemRead = 1; EX_wr = 31;
        cyc();
        checks++;
        if (hz_state !== 1'b1) begin
            errors++; $display("FAIL rh_enter: got %b expected 1", hz_state);
        end
        reset = 1; #1;
        checks++;
        if (ctl !== C_NONE || hz_state !== 1'b0) begin
            errors++; $display("FAIL rh_during: got ctl=%b st=%b expected 0/0", ctl, hz_state);
        end
        cyc(); reset = 0; #1;
        checks++;
        if (ctl !== C_STALL || hz_state !== 1'b0) begin
            errors++;
            $display("FAIL rh_after: got ctl=%b st=%b expected %b st=0", ctl, hz_state, C_STALL);
        end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++; $display("FAIL rh_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        idle(); #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL rh_idle: got %b expected %b", ctl, C_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_jr_after_load();
        test_branch();
        test_terms();
        test_counters();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
